// File: rtl/tohost_pkg.sv
// Shared encodings and defaults for the tohost end-of-test monitor.
// Used by the RTL and by benches that need the same tohost address.
package tohost_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } status_e;

    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

endpackage

// File: rtl/tohost_watchdog.sv
// Saturating run-cycle counter with a terminal-count compare.
// expired is high during the last permitted enabled cycle.
module tohost_watchdog #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    // Compared at 64 bits so a timeout beyond the counter range simply never fires.
    localparam logic [63:0] LAST_CYCLE = 64'(TIMEOUT_CYCLES) - 64'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = en && (64'(count) == LAST_CYCLE);

endmodule

// File: rtl/tohost_monitor.sv
// End-of-test detector: snoops stores to the tohost word and latches
// PASS / FAIL / TIMEOUT, freezing the cycle count and raising halt.
module tohost_monitor
    import tohost_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned BLINK_BIT      = 23
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [3:0]       mem_we,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    output logic             halt,
    output logic [1:0]       test_status,
    output logic [31:0]      fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [3:0]       led
);

    status_e state_q, state_d;
    logic    run;
    logic    hit;
    logic    expired;
    logic    unused_addr_bits;

    assign run = (state_q == ST_RUN);

    // Byte lanes within the tohost word are irrelevant: any store to it hits.
    assign hit = (|mem_we) && (mem_addr[31:2] == TOHOST_ADDR[31:2]) && (mem_wdata != '0);
    assign unused_addr_bits = ^mem_addr[1:0];

    tohost_watchdog #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .en      (run),
        .count   (cycle_count),
        .expired (expired)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A hit in the final watchdog cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        if (run) begin
            if (hit) begin
                state_d = (mem_wdata == 32'd1) ? ST_PASS : ST_FAIL;
            end else if (expired) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fail_code <= '0;
        end else if (run && hit && (mem_wdata != 32'd1)) begin
            fail_code <= {1'b0, mem_wdata[31:1]};
        end
    end

    always_comb begin
        halt        = !run;
        test_status = state_q;
        led         = 4'b0000;
        case (state_q)
            ST_RUN:     led[0] = cycle_count[BLINK_BIT];
            ST_PASS:    led[1] = 1'b1;
            ST_FAIL:    led[2] = 1'b1;
            ST_TIMEOUT: led[3] = 1'b1;
            default:    led    = 4'b0000;
        endcase
    end

endmodule

// File: doc/tohost_monitor.md
Name: tohost_monitor

Overview:
Synthesizable end-of-test detector on the CPU data-memory store port; the hardware counterpart of the simulation tohost check.
Snoops every store the core issues. A non-zero word written to TOHOST_ADDR ends the test: 1 means pass, any other value means fail with code wdata[31:1]. A watchdog declares timeout if no such write ever arrives.
On a terminal result it freezes the cycle counter, raises halt to the top level for core clock-gating/stall, and drives status LEDs for board runs.

Parameters:
TOHOST_ADDR, 32'h0000_1000, byte address of the tohost word (word-aligned)
TIMEOUT_CYCLES, 1000000, cycles in RUN before TIMEOUT is declared
CNT_W, 32, width of cycle counter
BLINK_BIT, 23, cycle_count bit driving the RUN heartbeat LED

Ports:
sys_clk  in  1  system clock, rising-edge
sys_rst_n  in  1  asynchronous active-low reset
mem_we  in  4  store byte enables from the core (same signal as top-level MemWrite_EN)
mem_addr  in  32  store byte address (MemAddr)
mem_wdata  in  32  store data (WriteData)
halt  out  1  sticky; high once a terminal state is reached
test_status  out  2  0=RUN, 1=PASS, 2=FAIL, 3=TIMEOUT
fail_code  out  32  {1'b0, wdata[31:1]} captured on FAIL; 0 otherwise
cycle_count  out  CNT_W  cycles spent in RUN
led  out  4  [0] heartbeat in RUN, [1] PASS, [2] FAIL, [3] TIMEOUT

Behaviour:
- Clock and reset: one clock domain, sys_clk. sys_rst_n is asynchronous assert, synchronous deassert handled at top.
- Reset values: test_status=RUN, halt=0, fail_code=0, cycle_count=0, led=4'b0000.
- Hit definition: hit = (|mem_we) && (mem_addr[31:2] == TOHOST_ADDR[31:2]) && (mem_wdata != 0).
  - Partial-byte stores count; the whole mem_wdata word is used.
  - A write of 0 is a no-op (riscv-tests clear tohost).
- State machine: RUN -> PASS | FAIL | TIMEOUT. All terminal states are sticky until reset.
  - RUN, hit with wdata==1 -> PASS.
  - RUN, hit with any other value -> FAIL; fail_code <= {1'b0, mem_wdata[31:1]}.
  - RUN, no hit, cycle_count == TIMEOUT_CYCLES-1 -> TIMEOUT.
  - Simultaneous hit and timeout in the same cycle: hit wins.
- Latency: inputs sampled on edge N; test_status, halt and fail_code are valid after edge N (one cycle). No combinational path from inputs to outputs.
- cycle_count:
  - Increments every RUN cycle.
  - Frozen on entry to a terminal state; the hit cycle itself is counted.
  - Saturates at all-ones and never wraps.
- Terminal states: stores (including to tohost) are ignored; fail_code and status are never overwritten.
- led:
  - led[0] = cycle_count[BLINK_BIT] while RUN, 0 otherwise.
  - led[3:1] is a registered one-hot of the terminal state.
- Reset mid-operation: returns to RUN with all counters cleared, regardless of current state.
- Misaligned mem_addr within the tohost word (low 2 bits non-zero) still hits.

Decomposition:
- Shared package tohost_pkg:
  - status encodings ST_RUN/ST_PASS/ST_FAIL/ST_TIMEOUT (2-bit).
  - default TOHOST_ADDR constant, for reuse by the testbench and the top-level address decoder.
- Optional sub-module tohost_watchdog: the saturating cycle counter plus timeout compare.
  - Ports: clk, rst_n, en, count, expired.
  - Keeps the FSM file small and lets the counter be unit-tested alone.

Test Plan:
- Store 32'h1 to 0x1000 with mem_we=4'hF at cycle 50 -> next edge test_status=1, halt=1, led=4'b0010, cycle_count=51, then stays frozen.
- Store 32'h7 to 0x1000 -> test_status=2, fail_code=32'h3, led[2]=1. A later store of 32'h1 leaves status=2 and fail_code=3.
- Store 0 to 0x1000, then stores to 0x1004 and 0x0FFC -> status stays 0, halt=0, counter keeps running.
- TIMEOUT_CYCLES=100, no stores -> status=3 after edge 100, cycle_count=100; with a pass store in cycle 99 instead -> status=1.
- Byte store (mem_we=4'b0001) of 32'h1 to 0x1002 -> PASS.
- Assert sys_rst_n low asynchronously mid-edge while in FAIL -> outputs clear immediately without a clock edge. After release, a pass write yields status=1.
